// File: rtl/nr_iter_ctrl.sv
// nr_iter_ctrl: Newton-Raphson iteration sequencer driving the F evaluator and handing F to the update stage
module nr_iter_ctrl #(
  parameter int         F_LATENCY = 24,
  parameter int         MAX_ITER  = 32,
  parameter logic [7:0] TOL_EXP   = 8'd103,
  parameter int         ITER_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       x0_init,
  input  logic [31:0]       x1_init,
  input  logic [31:0]       x2_init,
  output logic [33:0]       x0,
  output logic [33:0]       x1,
  output logic [33:0]       x2,
  input  logic [31:0]       f0,
  input  logic [31:0]       f1,
  input  logic [31:0]       f2,
  input  logic [31:0]       f3,
  output logic [31:0]       f0_q,
  output logic [31:0]       f1_q,
  output logic [31:0]       f2_q,
  output logic [31:0]       f3_q,
  output logic              f_valid,
  input  logic              upd_valid,
  input  logic [31:0]       x0_next,
  input  logic [31:0]       x1_next,
  input  logic [31:0]       x2_next,
  output logic              upd_ready,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              nan_err,
  output logic [ITER_W-1:0] iter_cnt
);
  localparam int CNT_W = $clog2(F_LATENCY);

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, CHECK, HANDOFF, FINISH} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] lat_cnt;
  logic [31:0]      x0_r, x1_r, x2_r;
  logic [3:0][7:0]  exps;
  logic             any_nf, all_small, at_limit, lat_done;

  assign x0        = {2'b00, x0_r};
  assign x1        = {2'b00, x1_r};
  assign x2        = {2'b00, x2_r};
  assign f_valid   = state == HANDOFF;
  assign upd_ready = f_valid;
  assign busy      = state != IDLE;
  assign done      = state == FINISH;
  assign exps      = {f3_q[30:23], f2_q[30:23], f1_q[30:23], f0_q[30:23]};
  assign at_limit  = iter_cnt == ITER_W'(MAX_ITER);
  assign lat_done  = lat_cnt == CNT_W'(F_LATENCY - 1);

  // classify the captured F: any non-finite lane, or every lane below tolerance (sign ignored)
  always_comb begin
    any_nf    = 1'b0;
    all_small = 1'b1;
    for (int i = 0; i < 4; i++) begin
      any_nf    = any_nf | (exps[i] == 8'hFF);
      all_small = all_small & (exps[i] < TOL_EXP);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state logic; the evaluator has no strobe so WAIT simply counts out its latency
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? WAIT : IDLE;
      WAIT:    state_n = lat_done ? CAPTURE : WAIT;
      CAPTURE: state_n = CHECK;
      CHECK:   state_n = (any_nf || all_small || at_limit) ? FINISH : HANDOFF;
      HANDOFF: state_n = upd_valid ? WAIT : HANDOFF;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // datapath: x load/update, F capture, iteration count, result flags, latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt   <= '0;
      x0_r      <= '0;
      x1_r      <= '0;
      x2_r      <= '0;
      f0_q      <= '0;
      f1_q      <= '0;
      f2_q      <= '0;
      f3_q      <= '0;
      iter_cnt  <= '0;
      converged <= 1'b0;
      nan_err   <= 1'b0;
    end else begin
      lat_cnt <= (state == WAIT) ? lat_cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        x0_r      <= x0_init;
        x1_r      <= x1_init;
        x2_r      <= x2_init;
        iter_cnt  <= '0;
        converged <= 1'b0;
        nan_err   <= 1'b0;
      end
      if (state == CAPTURE) begin
        f0_q     <= f0;
        f1_q     <= f1;
        f2_q     <= f2;
        f3_q     <= f3;
        iter_cnt <= iter_cnt + 1'b1;
      end
      if (state == CHECK) begin
        nan_err   <= any_nf;
        converged <= !any_nf && all_small;
      end
      if (state == HANDOFF && upd_valid) begin
        x0_r <= x0_next;
        x1_r <= x1_next;
        x2_r <= x2_next;
      end
    end
  end
endmodule

// File: tb/tb_nr_iter_ctrl.sv
// tb_nr_iter_ctrl: scoreboard bench with a delayed-lookup evaluator model and randomized runs
module tb_nr_iter_ctrl;
  localparam int         LAT  = 24;
  localparam int         MAXI = 3;
  localparam logic [7:0] TOL  = 8'd103;

  logic        clk, rst, start, upd_valid;
  logic [31:0] x0_init, x1_init, x2_init, x0_next, x1_next, x2_next;
  logic [31:0] f0, f1, f2, f3, f0_q, f1_q, f2_q, f3_q;
  logic [33:0] x0, x1, x2;
  logic        f_valid, upd_ready, busy, done, converged, nan_err;
  logic [5:0]  iter_cnt;

  nr_iter_ctrl #(.F_LATENCY(LAT), .MAX_ITER(MAXI), .TOL_EXP(TOL), .ITER_W(6)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0_init(x0_init), .x1_init(x1_init), .x2_init(x2_init),
    .x0(x0), .x1(x1), .x2(x2),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3),
    .f0_q(f0_q), .f1_q(f1_q), .f2_q(f2_q), .f3_q(f3_q),
    .f_valid(f_valid), .upd_valid(upd_valid),
    .x0_next(x0_next), .x1_next(x1_next), .x2_next(x2_next),
    .upd_ready(upd_ready), .busy(busy), .done(done),
    .converged(converged), .nan_err(nan_err), .iter_cnt(iter_cnt)
  );

  typedef struct {bit conv; bit nan; int n; logic [127:0] f;} res_t;

  res_t         rq[$];
  logic [127:0] fq[$];
  logic [101:0] xq[$];
  logic [127:0] fmap[logic [31:0]];
  logic [127:0] pipe[LAT];
  logic [127:0] plan[$];
  logic [31:0]  keys[$];
  int           h, force_dly, vec, bad, cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] lookup(input logic [31:0] k);
    return fmap.exists(k) ? fmap[k] : {4{32'h40490FDB}};
  endfunction

  // evaluator model: F of the current x0 appears LAT cycles later, stale values before that
  always @(posedge clk) begin
    pipe[0] <= lookup(x0[31:0]);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {f3, f2, f1, f0} = pipe[LAT-1];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    vec++;
    bad++;
    $display("FAIL %s: got event with nothing expected", nm);
  endtask

  // reference: walk the planned evaluations and apply nan > converged > limit
  function automatic void model(input logic [127:0] p[$], output int n, output bit conv, output bit nan);
    logic [127:0] v;
    logic [7:0]   e;
    bit           ff, sm;
    conv = 0;
    nan  = 0;
    n    = 0;
    for (int i = 0; i < MAXI; i++) begin
      n  = i + 1;
      v  = p[i];
      ff = 0;
      sm = 1;
      for (int j = 0; j < 4; j++) begin
        e = v[j*32+23 +: 8];
        if (e == 8'hFF) ff = 1;
        if (e >= TOL) sm = 0;
      end
      if (ff) begin nan = 1; return; end
      if (sm) begin conv = 1; return; end
    end
  endfunction

  function automatic logic [31:0] rword(input int m);
    logic [7:0] e;
    case (m)
      0:       e = 8'($urandom_range(0, 102));
      1:       e = 8'($urandom_range(102, 103));
      2:       e = 8'($urandom_range(103, 254));
      default: e = 8'hFF;
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // monitor: compares reset values, x updates, handoff F and final results against the queues
  initial begin
    logic [101:0] last_x;
    logic [127:0] held;
    bit           fv_prev;
    res_t         r;
    last_x  = '0;
    held    = '0;
    fv_prev = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("reset_x", {x2, x1, x0}, '0);
        chk("reset_fq", {f3_q, f2_q, f1_q, f0_q}, '0);
        chk("reset_flags", {f_valid, upd_ready, busy, done, converged, nan_err, iter_cnt}, '0);
        last_x  = '0;
        fv_prev = 0;
      end else begin
        if ({x2, x1, x0} !== last_x) begin
          if (xq.size() == 0) miss("x_update");
          else chk("x_update", {x2, x1, x0}, xq.pop_front());
          last_x = {x2, x1, x0};
        end
        if (f_valid) begin
          if (!fv_prev) begin
            if (fq.size() == 0) miss("handoff");
            else held = fq.pop_front();
          end
          chk("handoff_fq", {f3_q, f2_q, f1_q, f0_q}, held);
          chk("upd_ready", upd_ready, 1'b1);
        end
        fv_prev = f_valid;
        if (done) begin
          if (rq.size() == 0) miss("done");
          else begin
            r = rq.pop_front();
            chk("converged", converged, r.conv);
            chk("nan_err", nan_err, r.nan);
            chk("iter_cnt", iter_cnt, r.n);
            chk("final_fq", {f3_q, f2_q, f1_q, f0_q}, r.f);
          end
        end
      end
    end
  end

  // update-stage model: random back-pressure in HANDOFF, stray upd_valid elsewhere
  initial begin
    int d;
    bit ho;
    d = 0;
    ho = 0;
    upd_valid = 0;
    x0_next = '0;
    x1_next = '0;
    x2_next = '0;
    forever begin
      @(negedge clk);
      if (f_valid) begin
        if (!ho) begin
          ho = 1;
          d = force_dly >= 0 ? force_dly : int'($urandom_range(0, 5));
        end
        if (d == 0 && h + 1 < keys.size()) begin
          upd_valid = 1;
          x0_next = keys[h+1];
          x1_next = $urandom;
          x2_next = $urandom;
          xq.push_back({2'b00, x2_next, 2'b00, x1_next, 2'b00, x0_next});
          h++;
        end else begin
          if (d > 0) d--;
          upd_valid = 0;
          x0_next = $urandom;
        end
      end else begin
        ho = 0;
        upd_valid = $urandom_range(0, 2) == 0;
        x0_next = $urandom;
        x1_next = $urandom;
        x2_next = $urandom;
      end
    end
  end

  task automatic do_run(input bit junk, output int c);
    int   n;
    bit   cv, nn;
    res_t r;
    model(plan, n, cv, nn);
    for (int i = 0; i < MAXI; i++) fmap[keys[i]] = plan[i];
    for (int i = 0; i < n - 1; i++) fq.push_back(plan[i]);
    r.conv = cv;
    r.nan  = nn;
    r.n    = n;
    r.f    = plan[n-1];
    rq.push_back(r);
    x0_init = keys[0];
    x1_init = $urandom;
    x2_init = $urandom;
    xq.push_back({2'b00, x2_init, 2'b00, x1_init, 2'b00, x0_init});
    h = 0;
    start = 1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      start = junk && busy && $urandom_range(0, 15) == 0;
      if (start) begin
        x0_init = $urandom;
        x1_init = $urandom;
        x2_init = $urandom;
      end
    end while (!done && c < 4000);
    if (!done) begin
      vec++;
      bad++;
      $display("FAIL run_timeout: got no done after %0d cycles expected done", c);
    end
    if (junk && $urandom_range(0, 1) == 1) begin
      start = 1;
      x0_init = $urandom;
    end
    @(negedge clk);
    start = 0;
    chk("start_in_done_ignored", busy, 1'b0);
  endtask

  initial begin
    vec = 0;
    bad = 0;
    h = 0;
    force_dly = -1;
    rst = 1;
    start = 0;
    x0_init = '0;
    x1_init = '0;
    x2_init = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    // immediate convergence and its latency
    plan = '{128'h0, 128'h0, 128'h0};
    keys = '{32'h0A000001, 32'h0A000002, 32'h0A000003};
    do_run(0, cyc);
    chk("conv_latency", cyc, 27);
    // one handoff held off for 5 cycles, then converge on 2^-25
    plan = '{{96'h0, 32'h3F800000}, {4{32'h33000000}}, 128'h0};
    keys = '{32'h0B000001, 32'h40000000, 32'h0B000003};
    force_dly = 5;
    do_run(0, cyc);
    // iteration limit with immediate updates
    plan = '{{64'h0, 32'h3F800000, 32'h0}, {64'h0, 32'h3F800000, 32'h0}, {64'h0, 32'h3F800000, 32'h0}};
    keys = '{32'h0C000001, 32'h0C000002, 32'h0C000003};
    force_dly = 0;
    do_run(0, cyc);
    force_dly = -1;
    // non-finite F: NaN on f2, then -Inf on f3
    plan = '{{32'h0, 32'h7FC00000, 64'h0}, 128'h0, 128'h0};
    keys = '{32'h0D000001, 32'h0D000002, 32'h0D000003};
    do_run(0, cyc);
    plan = '{{32'hFF800000, 96'h0}, 128'h0, 128'h0};
    keys = '{32'h0E000001, 32'h0E000002, 32'h0E000003};
    do_run(0, cyc);
    // tolerance boundary: exponent 102 converges, 103 on one lane does not
    plan = '{{4{32'h33000000}}, 128'h0, 128'h0};
    keys = '{32'h0F000001, 32'h0F000002, 32'h0F000003};
    do_run(0, cyc);
    plan = '{{32'h33800000, {3{32'h33000000}}}, {32'h33800000, {3{32'h33000000}}}, {32'h33800000, {3{32'h33000000}}}};
    keys = '{32'h0F100001, 32'h0F100002, 32'h0F100003};
    do_run(0, cyc);
    // reset during WAIT, with a start issued while busy first
    plan = '{128'h0, 128'h0, 128'h0};
    keys = '{32'h0F200001, 32'h0F200002, 32'h0F200003};
    for (int i = 0; i < MAXI; i++) fmap[keys[i]] = plan[i];
    x0_init = keys[0];
    x1_init = 32'h11111111;
    x2_init = 32'h22222222;
    xq.push_back({2'b00, x2_init, 2'b00, x1_init, 2'b00, x0_init});
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    start = 1;
    x0_init = 32'h0F2000FF;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    chk("idle_after_reset", {busy, done}, 2'b00);
    // randomized runs
    for (int r = 0; r < 40; r++) begin
      plan.delete();
      keys.delete();
      for (int i = 0; i < MAXI; i++) begin
        logic [127:0] v;
        int m;
        m = int'($urandom_range(0, 7));
        for (int j = 0; j < 4; j++) v[j*32 +: 32] = rword(m < 3 ? 0 : m == 3 ? 3 : int'($urandom_range(0, 2)));
        if (m == 3) v[$urandom_range(0, 3)*32 + 23 +: 8] = 8'hFF;
        plan.push_back(v);
        keys.push_back(32'h10000000 | (r << 8) | i);
      end
      do_run(1, cyc);
    end
    repeat (5) @(negedge clk);
    chk("rq_drained", rq.size(), 0);
    chk("fq_drained", fq.size(), 0);
    chk("xq_drained", xq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/nr_iter_ctrl.md
Name: nr_iter_ctrl

Overview:
- Iteration sequencer and initiator for the F-vector evaluator in the Newton-Raphson datapath.
- Drives the x vector into the pipelined evaluator and waits a fixed pipeline latency, since the evaluator has no valid strobe.
- Captures f0..f3, tests convergence on IEEE-754 single exponents, then hands F to the downstream Jacobian/update stage and accepts the next x via valid/ready.
- Repeats until converged, the iteration limit is reached, or a non-finite F appears.

Parameters:
- F_LATENCY, 24: cycles from a new x on x0..x2 until f0..f3 are valid; must be ≥2.
- MAX_ITER, 32: maximum F evaluations per run; must be ≥1.
- TOL_EXP, 8'd103: |f| counts as converged when exponent field < TOL_EXP, i.e. |f| < 2^-24.
- ITER_W, 6: width of iter_cnt; 2^ITER_W must exceed MAX_ITER.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request to begin a run; ignored unless the FSM is in IDLE.
- x0_init, x1_init, x2_init, in, 32 each: initial guess, IEEE single; sampled on an accepted start.
- x0, x1, x2, out, 34 each: to the evaluator; [31:0] is the IEEE value, [33:32] is always 0.
- f0, f1, f2, f3, in, 32 each: from the evaluator.
- f0_q, f1_q, f2_q, f3_q, out, 32 each: captured F values.
- f_valid, out, 1: high while f*_q holds a result awaiting update; this is the ready/valid source to the update stage.
- upd_valid, in, 1: next x presented on x0_next..x2_next.
- x0_next, x1_next, x2_next, in, 32 each: next iterate.
- upd_ready, out, 1: equal to f_valid.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse when a run ends.
- converged, out, 1: result flag, valid from done until the next accepted start.
- nan_err, out, 1: result flag, valid from done until the next accepted start.
- iter_cnt, out, ITER_W: number of F captures in the current or last run.

Behaviour:
- Reset:
  - Outputs: x0..x2=0, f*_q=0, f_valid=0, busy=0, done=0, converged=0, nan_err=0, iter_cnt=0.
  - FSM returns to IDLE and the latency counter clears.
  - Reset mid-run aborts immediately with no done pulse.
- States: IDLE, WAIT, CAPTURE, CHECK, HANDOFF, FINISH.
- IDLE:
  - On start=1: load x* from x*_init, clear converged, nan_err and iter_cnt, clear the latency counter, go to WAIT.
- WAIT:
  - x* held constant; the counter increments each cycle.
  - When counter == F_LATENCY-1, go to CAPTURE, so f is sampled F_LATENCY cycles after x changed.
- CAPTURE:
  - f*_q <= f*; iter_cnt += 1; go to CHECK.
- CHECK (evaluated on f*_q):
  - If any exponent field == 8'hFF: nan_err=1, go to FINISH.
  - Otherwise, if all four have exponent < TOL_EXP: converged=1, go to FINISH. Sign is ignored; zero and denormals count as converged.
  - Otherwise, if iter_cnt == MAX_ITER: go to FINISH with converged=0.
  - Otherwise go to HANDOFF.
  - Precedence: nan_err > converged > iteration limit.
- HANDOFF:
  - f_valid=1 and upd_ready=1; f*_q stays stable.
  - On upd_valid=1 (the transfer cycle): x* <= x*_next with upper bits 0, f_valid drops next cycle, counter clears, go to WAIT.
  - upd_valid while not in HANDOFF is ignored.
- FINISH:
  - done=1 for exactly one cycle, go to IDLE.
  - converged, nan_err, iter_cnt and f*_q hold their values.
- start while busy is ignored.
- start in the same cycle as the done pulse is ignored; a restart is accepted one cycle later, in IDLE.
- Timing:
  - First capture occurs F_LATENCY+1 cycles after the accepted start edge.
  - Each subsequent iteration adds F_LATENCY+1 cycles plus the HANDOFF wait.

Test Plan:
- Immediate convergence: start with all f*=0 held constant, F_LATENCY=24. Required: done pulses at cycle 27 after the start edge, converged=1, nan_err=0, iter_cnt=1, f_valid never asserted.
- Iteration with back-pressure: f0=32'h3F800000 (1.0) on the first evaluation, then 32'h33000000 (2^-25) for all f on the second; upd_valid held low 5 cycles in HANDOFF with x0_next=32'h40000000. Required:
  - f*_q stable and f_valid=1 for those 5 cycles.
  - x0 becomes 34'h040000000 the cycle after the transfer.
  - converged=1, iter_cnt=2.
- Iteration limit: MAX_ITER=3, f1=32'h3F800000 forever, upd_valid tied high. Required: exactly 3 captures, done with converged=0, iter_cnt=3.
- Non-finite F: f2=32'h7FC00000 (NaN) while the others are 0. Required: nan_err=1, converged=0, done after the first capture. Repeat with f3=32'hFF800000 (-Inf): same result.
- Tolerance boundary: all f with exponent 102 (32'h33000000) gives converged; one f with exponent 103 (32'h33800000) and MAX_ITER=1 gives converged=0.
- Reset and restart: assert rst during WAIT. Required: all outputs return to reset values the next cycle and no done pulse. start during busy is ignored, and a new start after reset runs normally.
